// File: rtl/matrix_mult_pkg.sv
// Shared definitions for the matrix-multiply accelerator tile.
//   mmState_e     : sequencing FSM states (IDLE, LOAD, COMPUTE, DONE)
//   minInputCount : shortest COMPUTE phase that still lets the last skewed
//                   operand pair reach the bottom-right PE (3N-1 steps)
package matrix_mult_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    COMPUTE = 2'd2,
    DONE    = 2'd3
  } mmState_e;

  function automatic int minInputCount(input int matrixSize);
    return 3 * matrixSize - 1;
  endfunction

endpackage

// File: rtl/systolic_pe.sv
// One processing element of the output-stationary systolic array.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   clear          : zero the accumulator and operand pipeline registers
//   en             : perform one multiply-accumulate step
//   a_in / a_out   : A operand from the left, forwarded one cycle later to the right
//   b_in / b_out   : B operand from above, forwarded one cycle later downward
//   acc            : running sum of a_in*b_in, wrapping modulo 2^DATA_SIZE
module systolic_pe #(
  parameter int DATA_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 en,
  input  logic [DATA_SIZE-1:0] a_in,
  input  logic [DATA_SIZE-1:0] b_in,
  output logic [DATA_SIZE-1:0] a_out,
  output logic [DATA_SIZE-1:0] b_out,
  output logic [DATA_SIZE-1:0] acc
);

  logic [DATA_SIZE-1:0] acc_q;
  logic [DATA_SIZE-1:0] aPipe_q;
  logic [DATA_SIZE-1:0] bPipe_q;
  logic [DATA_SIZE-1:0] product;

  // The product is evaluated at DATA_SIZE width, so the upper half of the
  // full product is discarded before it is added to the accumulator.
  assign product = a_in * b_in;

  // Accumulate and forward operands only while enabled; otherwise hold.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      acc_q   <= '0;
      aPipe_q <= '0;
      bPipe_q <= '0;
    end else if (en) begin
      acc_q   <= acc_q + product;
      aPipe_q <= a_in;
      bPipe_q <= b_in;
    end
  end

  assign a_out = aPipe_q;
  assign b_out = bPipe_q;
  assign acc   = acc_q;

endmodule

// File: rtl/matrix_multiply_controller.sv
// Matrix-multiply accelerator tile: C = A x B on an N x N systolic array.
// Ports:
//   clk        : system clock
//   reset      : synchronous active-high reset, aborts any run in progress
//   start      : launches a run when sampled high in IDLE or DONE
//   done       : high while the FSM sits in DONE
//   in_store_a : matrix A [row][col], captured on the launching edge
//   in_store_b : matrix B [row][col], captured on the launching edge
//   out_matrix : result, C[i][j] at index i*N+j, held until the next result
module matrix_multiply_controller
  import matrix_mult_pkg::*;
#(
  parameter int MATRIX_SIZE = 3,
  parameter int DATA_SIZE   = 8,
  parameter int INPUT_COUNT = MATRIX_SIZE * MATRIX_SIZE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 done,
  input  logic [DATA_SIZE-1:0] in_store_a [MATRIX_SIZE][MATRIX_SIZE],
  input  logic [DATA_SIZE-1:0] in_store_b [MATRIX_SIZE][MATRIX_SIZE],
  output logic [DATA_SIZE-1:0] out_matrix [MATRIX_SIZE*MATRIX_SIZE]
);

  localparam int CountWidth = (INPUT_COUNT > 1) ? $clog2(INPUT_COUNT) : 1;
  localparam int IdxW       = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1;
  localparam logic [CountWidth-1:0] LastCount = CountWidth'(INPUT_COUNT - 1);
  localparam logic [CountWidth-1:0] SizeCount = CountWidth'(MATRIX_SIZE);

  if (INPUT_COUNT < minInputCount(MATRIX_SIZE)) begin : gBadInputCount
    $error("INPUT_COUNT too small for the operand skew of this MATRIX_SIZE");
  end

  mmState_e              state_q, state_d;
  logic [CountWidth-1:0] count_q, count_d;
  logic                  captureInputs;
  logic                  loadResult;
  logic                  clearPe;
  logic                  enPe;

  logic [DATA_SIZE-1:0] matA_q      [MATRIX_SIZE][MATRIX_SIZE];
  logic [DATA_SIZE-1:0] matB_q      [MATRIX_SIZE][MATRIX_SIZE];
  logic [DATA_SIZE-1:0] outMatrix_q [MATRIX_SIZE*MATRIX_SIZE];

  logic [DATA_SIZE-1:0] aFeed       [MATRIX_SIZE];
  logic [DATA_SIZE-1:0] bFeed       [MATRIX_SIZE];
  logic [DATA_SIZE-1:0] aIn         [MATRIX_SIZE][MATRIX_SIZE];
  logic [DATA_SIZE-1:0] bIn         [MATRIX_SIZE][MATRIX_SIZE];
  logic [DATA_SIZE-1:0] accArr      [MATRIX_SIZE][MATRIX_SIZE];
  logic [DATA_SIZE-1:0] accFlat     [MATRIX_SIZE*MATRIX_SIZE];
  logic [DATA_SIZE-1:0] unusedAOut  [MATRIX_SIZE];
  logic [DATA_SIZE-1:0] unusedBOut  [MATRIX_SIZE];

  // Next-state logic. The counter doubles as the feeder time step t, and the
  // result is latched on the final COMPUTE edge, after the last nonzero
  // product has already landed in the bottom-right PE.
  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    captureInputs = 1'b0;
    loadResult    = 1'b0;
    clearPe       = 1'b0;
    enPe          = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d       = LOAD;
          captureInputs = 1'b1;
        end
      end
      LOAD: begin
        clearPe = 1'b1;
        count_d = '0;
        state_d = COMPUTE;
      end
      COMPUTE: begin
        enPe = 1'b1;
        if (count_q == LastCount) begin
          state_d    = DONE;
          loadResult = 1'b1;
          count_d    = '0;
        end else begin
          count_d = count_q + CountWidth'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter, operand copies and result register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      matA_q      <= '{default: '0};
      matB_q      <= '{default: '0};
      outMatrix_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (captureInputs) begin
        matA_q <= in_store_a;
        matB_q <= in_store_b;
      end
      if (loadResult) begin
        outMatrix_q <= accFlat;
      end
    end
  end

  // Skewed feeders: row i of A is delayed by i steps and column j of B by
  // j steps, so matching A[i][k] and B[k][j] meet inside PE(i,j).
  for (genvar f = 0; f < MATRIX_SIZE; f++) begin : gFeed
    logic [CountWidth-1:0] offset;
    logic                  inWindow;
    assign offset   = count_q - CountWidth'(f);
    assign inWindow = (count_q >= CountWidth'(f)) && (offset < SizeCount);
    assign aFeed[f] = inWindow ? matA_q[f][offset[IdxW-1:0]] : '0;
    assign bFeed[f] = inWindow ? matB_q[offset[IdxW-1:0]][f] : '0;
  end

  // PE grid: A flows right along rows, B flows down along columns. Operands
  // leaving the right and bottom edges have no consumer.
  for (genvar i = 0; i < MATRIX_SIZE; i++) begin : gRow
    assign aIn[i][0] = aFeed[i];
    assign bIn[0][i] = bFeed[i];
    for (genvar j = 0; j < MATRIX_SIZE; j++) begin : gCol
      logic [DATA_SIZE-1:0] aOutW;
      logic [DATA_SIZE-1:0] bOutW;

      systolic_pe #(.DATA_SIZE(DATA_SIZE)) uPe (
        .clk   (clk),
        .reset (reset),
        .clear (clearPe),
        .en    (enPe),
        .a_in  (aIn[i][j]),
        .b_in  (bIn[i][j]),
        .a_out (aOutW),
        .b_out (bOutW),
        .acc   (accArr[i][j])
      );

      if (j < MATRIX_SIZE - 1) begin : gPassA
        assign aIn[i][j+1] = aOutW;
      end else begin : gEdgeA
        assign unusedAOut[i] = aOutW;
      end

      if (i < MATRIX_SIZE - 1) begin : gPassB
        assign bIn[i+1][j] = bOutW;
      end else begin : gEdgeB
        assign unusedBOut[j] = bOutW;
      end

      assign accFlat[i*MATRIX_SIZE+j] = accArr[i][j];
    end
  end

  assign done       = (state_q == DONE);
  assign out_matrix = outMatrix_q;

endmodule

// File: tb/tb_matrix_multiply_controller.sv
// Self-checking bench for matrix_multiply_controller (N=3, 8-bit, 9 COMPUTE steps).
// Table of {A, B, expected C} records plus hand-written sequences for
// back-to-back runs, mid-run reset and a continuously held start.
module tb_matrix_multiply_controller;

  localparam int N  = 3;
  localparam int W  = 8;
  localparam int IC = N * N;
  localparam int ExpLatency = IC + 2;

  typedef logic [N*N-1:0][W-1:0] mat_t;

  typedef struct packed {
    mat_t a;
    mat_t b;
    mat_t c;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         done;
  logic [W-1:0] inA  [N][N];
  logic [W-1:0] inB  [N][N];
  logic [W-1:0] outM [N*N];

  int applied     = 0;
  int miscompares = 0;

  vec_t  vecs  [5];
  string names [5];

  mat_t matDefA, matDefB, matDefC, matIdent, matZero;

  matrix_multiply_controller #(
    .MATRIX_SIZE (N),
    .DATA_SIZE   (W),
    .INPUT_COUNT (IC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .done       (done),
    .in_store_a (inA),
    .in_store_b (inB),
    .out_matrix (outM)
  );

  always #5 clk = ~clk;

  // Absolute time limit so a stuck DUT still ends the run.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, summary not produced");
    $fatal(1, "[TB] watchdog");
  end

  function automatic mat_t m9(input int e0, input int e1, input int e2,
                              input int e3, input int e4, input int e5,
                              input int e6, input int e7, input int e8);
    mat_t m;
    m[0] = 8'(e0); m[1] = 8'(e1); m[2] = 8'(e2);
    m[3] = 8'(e3); m[4] = 8'(e4); m[5] = 8'(e5);
    m[6] = 8'(e6); m[7] = 8'(e7); m[8] = 8'(e8);
    return m;
  endfunction

  function automatic mat_t fill9(input int v);
    return m9(v, v, v, v, v, v, v, v, v);
  endfunction

  task automatic checkValue(input string name, input int actual, input int expected);
    applied++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkOutput(input string name, input mat_t expected);
    for (int k = 0; k < N*N; k++) begin
      checkValue($sformatf("%s c[%0d]", name, k), int'(outM[k]), int'(expected[k]));
    end
  endtask

  task automatic driveInputs(input mat_t a, input mat_t b);
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        inA[i][j] = a[i*N+j];
        inB[i][j] = b[i*N+j];
      end
    end
  endtask

  // Called at the falling edge right after the start-sampling edge (edge 0).
  // lat is the index of the first rising edge that samples done high.
  task automatic waitDone(output int lat);
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      if (done) begin
        lat = k + 1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // One-cycle start pulse, then the inputs are overwritten to prove the run
  // works from the captured copies only.
  task automatic applyStimulus(input mat_t a, input mat_t b, output int lat);
    @(negedge clk);
    driveInputs(a, b);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    driveInputs(fill9(255), fill9(255));
    waitDone(lat);
  endtask

  task automatic runVector(input string name, input vec_t v);
    int lat;
    applyStimulus(v.a, v.b, lat);
    checkValue({name, " latency"}, lat, ExpLatency);
    checkOutput(name, v.c);
  endtask

  initial begin
    int lat;
    int sawDone;

    matDefA  = m9(1, 2, 3, 4, 5, 6, 7, 8, 9);
    matDefB  = m9(2, 4, 6, 1, 5, 9, 3, 7, 8);
    matDefC  = m9(13, 35, 48, 31, 83, 117, 49, 131, 186);
    matIdent = m9(1, 0, 0, 0, 1, 0, 0, 0, 1);
    matZero  = fill9(0);

    vecs[0] = '{a: matDefA,    b: matDefB,    c: matDefC};    names[0] = "default";
    vecs[1] = '{a: matIdent,   b: matDefB,    c: matDefB};    names[1] = "identity";
    vecs[2] = '{a: matZero,    b: matDefB,    c: matZero};    names[2] = "zeroA";
    vecs[3] = '{a: fill9(16),  b: fill9(16),  c: fill9(0)};   names[3] = "wrap16";
    vecs[4] = '{a: fill9(10),  b: fill9(10),  c: fill9(44)};  names[4] = "wrap10";

    reset = 1'b1;
    start = 1'b0;
    driveInputs(matZero, matZero);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checkValue("reset done", int'(done), 0);
    checkOutput("reset", matZero);

    for (int v = 0; v < 5; v++) begin
      runVector(names[v], vecs[v]);
    end

    // Back-to-back: default result, linger in DONE, then relaunch with A=I.
    runVector("b2b first", vecs[0]);
    repeat (3) @(negedge clk);
    checkValue("b2b hold done", int'(done), 1);
    checkOutput("b2b hold", matDefC);
    driveInputs(matIdent, matDefB);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    checkValue("b2b done drop", int'(done), 0);
    checkOutput("b2b old kept", matDefC);
    repeat (5) @(negedge clk);
    checkOutput("b2b mid run", matDefC);
    waitDone(lat);
    checkValue("b2b latency", lat, ExpLatency - 5);
    checkOutput("b2b second", matDefB);

    // Reset while COMPUTE is at t=3 (state after edge 4 of the run).
    @(negedge clk);
    driveInputs(matDefA, matDefB);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkValue("midreset done", int'(done), 0);
    checkOutput("midreset", matZero);
    sawDone = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) sawDone = 1;
    end
    checkValue("midreset stays idle", sawDone, 0);
    runVector("after reset", vecs[0]);

    // start held high throughout: run completes, then relaunches at once.
    @(negedge clk);
    driveInputs(matDefA, matDefB);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    waitDone(lat);
    checkValue("held latency", lat, ExpLatency);
    checkOutput("held", matDefC);
    @(negedge clk);
    checkValue("held done width", int'(done), 0);
    start = 1'b0;
    waitDone(lat);
    checkValue("held relaunch latency", lat, ExpLatency);
    checkOutput("held relaunch", matDefC);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule

// File: doc/matrix_multiply_controller.md
Name: matrix_multiply_controller

Overview:
Computes C = A x B for two square MATRIX_SIZE x MATRIX_SIZE unsigned matrices on an output-stationary systolic array of processing elements (PEs). Includes its own sequencing FSM and skewed operand feeders. A single start pulse launches a run; done reports a completed run, and the row-major flattened result remains readable afterwards. The block is a self-contained matrix-multiply accelerator tile.

Parameters:
MATRIX_SIZE, 3, matrix dimension N; the array has N*N PEs.
DATA_SIZE, 8, bit width of every operand and result element.
INPUT_COUNT, MATRIX_SIZE*MATRIX_SIZE, number of clock cycles the COMPUTE state lasts. Elaboration error if INPUT_COUNT < 3*MATRIX_SIZE-1.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  launches a run when sampled high in IDLE or DONE.
done  output  1  high while in the DONE state.
in_store_a  input  [DATA_SIZE-1:0] x [N][N]  matrix A, indexed [row][col].
in_store_b  input  [DATA_SIZE-1:0] x [N][N]  matrix B, indexed [row][col].
out_matrix  output  [DATA_SIZE-1:0] x [N*N]  result; element C[i][j] is at index i*N+j.

Behaviour:
- Reset, synchronous and active-high:
  - state goes to IDLE.
  - done = 0; out_matrix all zero.
  - PE accumulators and pipeline registers, the captured A/B copies, and the cycle counter are all cleared.
  - Reset asserted mid-run aborts the run; no done is produced.
- FSM states: IDLE, LOAD, COMPUTE, DONE.
  - IDLE: on the edge where start=1 -> LOAD; A and B are captured into internal registers on that edge.
  - LOAD: clears all PE accumulators and a/b pipeline registers and zeroes the counter; the next edge always goes to COMPUTE.
  - COMPUTE: counter t runs 0..INPUT_COUNT-1, one step per edge. On the edge with t = INPUT_COUNT-1 -> DONE, and out_matrix is loaded from the accumulators on that same edge.
  - DONE: done = 1 and out_matrix is held. On start=1 -> LOAD, recapturing A and B; done drops on that edge.
- start is ignored in LOAD and COMPUTE. Input changes after the capture edge do not affect the running result.
- Latency: done rises on the (INPUT_COUNT+2)th rising edge after the start-sampling edge, counting that edge as 0. For the defaults this is 11 edges after start is sampled.
- Feeding in COMPUTE step t:
  - the row-i A feeder presents A[i][t-i] if 0 <= t-i < N, else 0.
  - the column-j B feeder presents B[t-j][j] if 0 <= t-j < N, else 0.
- PE(i,j), in COMPUTE, on each edge:
  - acc += a_in*b_in.
  - a_out <= a_in, passed right to PE(i,j+1).
  - b_out <= b_in, passed down to PE(i+1,j).
  - PEs are idle in all other states.
- Arithmetic: unsigned. The product is truncated to DATA_SIZE bits; the accumulator is DATA_SIZE bits and wraps modulo 2^DATA_SIZE. No saturation and no overflow flag.
- The last nonzero product reaches PE(N-1,N-1) at t = 3N-3, so all accumulators are final before the out_matrix load edge.

Decomposition:
- Package matrix_mult_pkg holds the FSM state enum (IDLE, LOAD, COMPUTE, DONE) and a function computing the minimum legal INPUT_COUNT (3N-1).
- One sub-module, systolic_pe, with parameter DATA_SIZE and ports clk, reset, clear, en, a_in, b_in, a_out, b_out, acc. It is instantiated N*N times by a generate loop.

Test Plan:
- Default run: A={{1,2,3},{4,5,6},{7,8,9}}, B={{2,4,6},{1,5,9},{3,7,8}}; reset 1 cycle, start pulse 1 cycle -> done rises 11 edges after the start-sampling edge, out_matrix = {13,35,48,31,83,117,49,131,186}.
- Identity: A=I, B=the default B -> out_matrix equals B flattened row-major; all-zero A -> all-zero out_matrix.
- Wrap-around: A all 16, B all 16 -> each element (3*256) mod 256 = 0. A all 10, B all 10 -> each element 300 mod 256 = 44.
- Back-to-back: run the default case, hold in DONE, then start with A=I -> done drops on the start edge and returns with the new result; out_matrix keeps its old value until the new DONE entry.
- Reset mid-COMPUTE: assert reset at t=3 -> the next cycle shows done=0, out_matrix all zero, state IDLE; a subsequent start gives the correct default result.
- start held high continuously through a run -> ignored in LOAD/COMPUTE; the run completes with the correct result, and on the first DONE cycle it relaunches immediately (done is high for one cycle).
